// File: rtl/dram_record_serializer.sv
// Splits one 256-bit accumulate-table record into eight {byte address, data word}
// entries for the DRAM write FIFO, stalling on FIFO full without dropping entries.
module dram_record_serializer #(
    parameter logic [31:0] DDR_LINE_BASE = 32'h0000_0000,
    parameter int          SLOT_WIDTH    = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rec_valid,
    output logic                  rec_ready,
    input  logic [SLOT_WIDTH-1:0] rec_slot,
    input  logic [255:0]          rec_data,
    output logic [63:0]           dram_fifo_writedata,
    output logic                  dram_fifo_write,
    input  logic                  dram_fifo_full,
    output logic                  busy,
    output logic [31:0]           rec_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q;
    logic [2:0]            cnt_q;
    logic [255:0]          data_q;
    logic [SLOT_WIDTH-1:0] slot_q;
    logic [31:0]           recCount_q;

    logic                  sendOk;
    logic                  lastWrite;
    logic                  accept;
    logic [31:0]           addr;
    logic [31:0]           wordSel;

    // A word leaves only when the FIFO can take it in the same cycle.
    assign sendOk    = (state_q == SEND) && !dram_fifo_full;
    assign lastWrite = sendOk && (cnt_q == 3'd7);
    assign rec_ready = (state_q == IDLE) || lastWrite;
    assign accept    = rec_valid && rec_ready;

    always_comb begin
        wordSel = data_q[{cnt_q, 5'b00000} +: 32];
        addr    = DDR_LINE_BASE + (32'(slot_q) << 5) + {27'b0, cnt_q, 2'b00};
        dram_fifo_write     = sendOk;
        dram_fifo_writedata = (state_q == SEND) ? {addr, wordSel} : 64'd0;
    end

    assign busy      = (state_q == SEND);
    assign rec_count = recCount_q;

    // Acceptance wins over the return to IDLE so back-to-back records have no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            data_q     <= '0;
            slot_q     <= '0;
            recCount_q <= 32'd0;
        end else begin
            if (accept) begin
                data_q  <= rec_data;
                slot_q  <= rec_slot;
                cnt_q   <= 3'd0;
                state_q <= SEND;
            end else if (lastWrite) begin
                cnt_q   <= 3'd0;
                state_q <= IDLE;
            end else if (sendOk) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (lastWrite) begin
                recCount_q <= recCount_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dram_record_serializer.sv
// Scoreboard bench for dram_record_serializer: accepted records push their eight
// expected FIFO entries, every observed write pops and compares one.
module tb_dram_record_serializer;

    localparam logic [31:0] HI_BASE = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rec_valid = 1'b0;
    logic         rec_ready;
    logic [19:0]  rec_slot = '0;
    logic [255:0] rec_data = '0;
    logic [63:0]  dram_fifo_writedata;
    logic         dram_fifo_write;
    logic         dram_fifo_full = 1'b0;
    logic         busy;
    logic [31:0]  rec_count;

    logic         hiValid = 1'b0;
    logic         hiReady;
    logic [19:0]  hiSlot = '0;
    logic [255:0] hiData = '0;
    logic [63:0]  hiWdata;
    logic         hiWrite;
    logic         hiFull = 1'b0;
    logic         hiBusy;
    logic [31:0]  hiCount;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    dram_record_serializer dut (
        .clk(clk), .reset_n(reset_n),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_slot(rec_slot), .rec_data(rec_data),
        .dram_fifo_writedata(dram_fifo_writedata), .dram_fifo_write(dram_fifo_write),
        .dram_fifo_full(dram_fifo_full), .busy(busy), .rec_count(rec_count)
    );

    dram_record_serializer #(.DDR_LINE_BASE(HI_BASE), .SLOT_WIDTH(20)) dutHi (
        .clk(clk), .reset_n(reset_n),
        .rec_valid(hiValid), .rec_ready(hiReady),
        .rec_slot(hiSlot), .rec_data(hiData),
        .dram_fifo_writedata(hiWdata), .dram_fifo_write(hiWrite),
        .dram_fifo_full(hiFull), .busy(hiBusy), .rec_count(hiCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [255:0] makeData(input logic [31:0] first);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = first + 32'(k);
        return d;
    endfunction

    // Presents a record and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [19:0] slot, input logic [31:0] first, input bit dropValid);
        bit accepted = 0;
        @(posedge clk); #1;
        rec_slot  = slot;
        rec_data  = makeData(first);
        rec_valid = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (rec_ready) accepted = 1;
            @(posedge clk); #1;
        end
        if (!accepted) checkOutput("acceptReady", {63'd0, rec_ready}, 64'd1);
        if (dropValid) rec_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, {63'd0, busy}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rec_valid && rec_ready) begin
                for (int k = 0; k < 8; k++)
                    sb.push_back({32'd0 + (32'(rec_slot) << 5) + 32'(k * 4), rec_data[32*k +: 32]});
            end
            if (dram_fifo_write) begin
                checkOutput("sbNonEmpty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) checkOutput("sbEntry", dram_fifo_writedata, sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstWrite", {63'd0, dram_fifo_write}, 64'd0);
        checkOutput("rstWdata", dram_fifo_writedata, 64'd0);
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        checkOutput("rstReady", {63'd0, rec_ready}, 64'd1);
        checkOutput("rstCount", 64'(rec_count), 64'd0);
        reset_n = 1'b1;

        // Single record: slot 3, words 0x10..0x17
        applyStimulus(20'd3, 32'h10, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("singleWrite", {63'd0, dram_fifo_write}, 64'd1);
            checkOutput("singleEntry", dram_fifo_writedata, {32'h60 + 32'(4 * i), 32'h10 + 32'(i)});
        end
        @(negedge clk);
        checkOutput("singleBusyLow", {63'd0, busy}, 64'd0);
        checkOutput("singleCount", 64'(rec_count), 64'd1);

        // Back-to-back: slots 0 and 1 with valid held high
        applyStimulus(20'd0, 32'hA000, 1'b0);
        rec_slot = 20'd1;
        rec_data = makeData(32'hB000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("b2bWriteA", {63'd0, dram_fifo_write}, 64'd1);
            checkOutput("b2bReadyA", {63'd0, rec_ready}, 64'(i == 7));
        end
        @(posedge clk); #1;
        rec_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("b2bWriteB", {63'd0, dram_fifo_write}, 64'd1);
            checkOutput("b2bReadyB", {63'd0, rec_ready}, 64'(i == 7));
        end
        @(negedge clk);
        checkOutput("b2bBusyLow", {63'd0, busy}, 64'd0);
        checkOutput("b2bCount", 64'(rec_count), 64'd3);

        // Backpressure: full for 5 cycles starting at cnt = 4
        applyStimulus(20'd5, 32'hC000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bpWritePre", {63'd0, dram_fifo_write}, 64'd1);
        end
        @(posedge clk); #1;
        dram_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bpStallWrite", {63'd0, dram_fifo_write}, 64'd0);
            checkOutput("bpStallHold", dram_fifo_writedata, {32'hA0 + 32'h10, 32'hC004});
        end
        @(posedge clk); #1;
        dram_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bpWritePost", {63'd0, dram_fifo_write}, 64'd1);
        end
        @(negedge clk);
        checkOutput("bpBusyLow", {63'd0, busy}, 64'd0);
        checkOutput("bpCount", 64'(rec_count), 64'd4);

        // Full while cnt = 7 with the next record already waiting
        applyStimulus(20'd7, 32'hD000, 1'b0);
        rec_slot = 20'd8;
        rec_data = makeData(32'hE000);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("lastWritePre", {63'd0, dram_fifo_write}, 64'd1);
        end
        @(posedge clk); #1;
        dram_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("lastReadyLow", {63'd0, rec_ready}, 64'd0);
            checkOutput("lastStallWrite", {63'd0, dram_fifo_write}, 64'd0);
            checkOutput("lastHold", dram_fifo_writedata, {32'hE0 + 32'h1C, 32'hD007});
        end
        @(posedge clk); #1;
        dram_fifo_full = 1'b0;
        @(negedge clk);
        checkOutput("lastReadyHigh", {63'd0, rec_ready}, 64'd1);
        checkOutput("lastWrite", {63'd0, dram_fifo_write}, 64'd1);
        @(posedge clk); #1;
        rec_valid = 1'b0;
        @(negedge clk);
        checkOutput("nextWord0", dram_fifo_writedata, {32'h100, 32'hE000});
        waitIdle("lastBusyLow");
        checkOutput("lastCount", 64'(rec_count), 64'd6);

        // Reset after three writes abandons the record
        applyStimulus(20'd9, 32'hF000, 1'b1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("midRstWrite", {63'd0, dram_fifo_write}, 64'd0);
        checkOutput("midRstBusy", {63'd0, busy}, 64'd0);
        checkOutput("midRstCount", 64'(rec_count), 64'd0);
        checkOutput("midRstReady", {63'd0, rec_ready}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        applyStimulus(20'd2, 32'h55, 1'b1);
        @(negedge clk);
        checkOutput("postRstOffset0", dram_fifo_writedata, {32'h40, 32'h55});
        waitIdle("postRstBusyLow");
        checkOutput("postRstCount", 64'(rec_count), 64'd1);

        // Address arithmetic at a high base with the largest slot
        @(posedge clk); #1;
        hiSlot  = 20'hFFFFF;
        hiData  = makeData(32'h700);
        hiValid = 1'b1;
        @(negedge clk);
        checkOutput("hiReady", {63'd0, hiReady}, 64'd1);
        @(posedge clk); #1;
        hiValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("hiWrite", {63'd0, hiWrite}, 64'd1);
            if (i == 0) checkOutput("hiWord0", hiWdata, {32'h81FF_FFE0, 32'h700});
            if (i == 7) checkOutput("hiWord7", hiWdata, {32'h81FF_FFFC, 32'h707});
        end
        @(negedge clk);
        checkOutput("hiCount", 64'(hiCount), 64'd1);

        checkOutput("sbDrained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
